// File: rtl/mem_ram_responder.sv
// RAM-side responder for the ramstate handshake: fixed-latency word memory
// that reports FREE/BUSY/ACCESS/ERROR and returns/commits 32-bit data.
package mem_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module mem_ram_responder
    import mem_types_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ramREN,
    input  logic                  ramWEN,
    input  logic [ADDR_WIDTH-1:0] ramaddr,
    input  logic [31:0]           ramstore,
    output ramstate_t             ramstate,
    output logic [31:0]           ramload
);
    localparam int unsigned CNT_W = ($clog2(LATENCY + 1) < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = ($clog2(MEM_DEPTH) < 1) ? 1 : $clog2(MEM_DEPTH);
    localparam int unsigned DATA_W = 32;

    ramstate_t             state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] lat_addr, addr_n;
    logic                  lat_wr, wr_n;
    logic [DATA_W-1:0]     load_n;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem [MEM_DEPTH];

    logic valid, conflict, oor, changed;

    assign valid    = ramREN ^ ramWEN;
    assign conflict = ramREN & ramWEN;
    assign oor      = 32'(ramaddr) >= MEM_DEPTH;
    assign changed  = (ramaddr != lat_addr) || (ramWEN != lat_wr);

    assign ramstate = state;

    // State, request latch, load data and word array; reset clears everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FREE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            ramload  <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat_addr <= addr_n;
            lat_wr   <= wr_n;
            ramload  <= load_n;
            if (mem_we) begin
                mem[lat_addr[IDX_W-1:0]] <= ramstore;
            end
        end
    end

    // Next state; ACCESS treats any present request as a fresh one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = lat_addr;
        wr_n    = lat_wr;
        load_n  = '0;
        mem_we  = 1'b0;
        case (state)
            FREE, ACCESS: begin
                if (conflict || (valid && oor)) begin
                    state_n = ERROR;
                end else if (valid) begin
                    state_n = BUSY;
                    addr_n  = ramaddr;
                    wr_n    = ramWEN;
                    cnt_n   = CNT_W'(LATENCY - 1);
                end else begin
                    state_n = FREE;
                end
            end
            BUSY: begin
                if (conflict) begin
                    state_n = ERROR;
                end else if (!valid || changed) begin
                    // Abort; a different valid request restarts the latency window.
                    if (valid && oor) begin
                        state_n = ERROR;
                    end else if (valid) begin
                        state_n = BUSY;
                        addr_n  = ramaddr;
                        wr_n    = ramWEN;
                        cnt_n   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_n = FREE;
                    end
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = ACCESS;
                    if (lat_wr) begin
                        mem_we = 1'b1;
                    end else begin
                        load_n = mem[lat_addr[IDX_W-1:0]];
                    end
                end
            end
            ERROR: begin
                if (!(ramREN || ramWEN)) begin
                    state_n = FREE;
                end
            end
            default: state_n = FREE;
        endcase
    end
endmodule

// File: tb/tb_mem_ram_responder.sv
// Directed bench for mem_ram_responder: vector table on a LATENCY=4 instance,
// hand sequences for async reset and a LATENCY=1 instance.
module tb_mem_ram_responder;
    import mem_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] store = '0;
    ramstate_t   st4, st1;
    logic [31:0] load4, load1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_ram_responder #(.LATENCY(4), .MEM_DEPTH(256), .ADDR_WIDTH(14)) u_dut4 (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramstate(st4), .ramload(load4)
    );

    mem_ram_responder #(.LATENCY(1), .MEM_DEPTH(256), .ADDR_WIDTH(14)) u_dut1 (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramstate(st1), .ramload(load1)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [13:0] addr;
        logic [31:0] store;
        ramstate_t   st;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic w, input logic [13:0] a,
                                input logic [31:0] d, input ramstate_t s, input logic [31:0] l);
        vec_t v;
        v.ren = r; v.wen = w; v.addr = a; v.store = d; v.st = s; v.load = l;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input ramstate_t act_st, input ramstate_t exp_st,
                       input logic [31:0] act_ld, input logic [31:0] exp_ld);
        checks++;
        if (act_st !== exp_st || act_ld !== exp_ld) begin
            failures++;
            $display("FAIL %s: got state=%0d load=%h, required state=%0d load=%h",
                     nm, act_st, act_ld, exp_st, exp_ld);
        end
    endtask

    // Drive one cycle of inputs at a negedge, then advance to the next negedge.
    task automatic step(input logic r, input logic w, input logic [13:0] a, input logic [31:0] d);
        ren = r; wen = w; addr = a; store = d;
        @(negedge CLK);
    endtask

    // Full write on the LATENCY=4 instance: 4 BUSY, ACCESS, then dropped -> FREE.
    function automatic void add_write(input logic [13:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, a, d, BUSY, 32'h0);
        add(1'b0, 1'b1, a, d, ACCESS, 32'h0);
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
    endfunction

    function automatic void add_read(input logic [13:0] a, input logic [31:0] exp);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, a, 32'h0, BUSY, 32'h0);
        add(1'b1, 1'b0, a, 32'h0, ACCESS, exp);
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
    endfunction

    initial begin
        // Write then read back
        add_write(14'h010, 32'hDEADBEEF);
        add_read(14'h010, 32'hDEADBEEF);
        // Address change mid-BUSY restarts the window
        add_write(14'h004, 32'h44444444);
        add_write(14'h008, 32'h88888888);
        add(1'b1, 1'b0, 14'h004, 32'h0, BUSY, 32'h0);
        add(1'b1, 1'b0, 14'h004, 32'h0, BUSY, 32'h0);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 14'h008, 32'h0, BUSY, 32'h0);
        add(1'b1, 1'b0, 14'h008, 32'h0, ACCESS, 32'h88888888);
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
        // Conflict -> sticky ERROR, no memory update
        add(1'b1, 1'b1, 14'h030, 32'hFFFFFFFF, ERROR, 32'h0);
        add(1'b1, 1'b0, 14'h030, 32'hFFFFFFFF, ERROR, 32'h0);
        add(1'b0, 1'b1, 14'h030, 32'hFFFFFFFF, ERROR, 32'h0);
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
        add_read(14'h030, 32'h0);
        // Out of range
        add(1'b1, 1'b0, 14'h100, 32'h0, ERROR, 32'h0);
        add(1'b1, 1'b0, 14'h100, 32'h0, ERROR, 32'h0);
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
        // Held read yields repeated accesses
        add_write(14'h001, 32'hCAFEF00D);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 14'h001, 32'h0, BUSY, 32'h0);
            add(1'b1, 1'b0, 14'h001, 32'h0, ACCESS, 32'hCAFEF00D);
        end
        add(1'b0, 1'b0, 14'h0, 32'h0, FREE, 32'h0);
        // Overwrite, then read-after-write sees the new value
        add_write(14'h010, 32'h0BADF00D);
        add_read(14'h010, 32'h0BADF00D);

        // Async reset before any clock edge
        #1 RST = 1'b1;
        #1;
        chk("reset_l4", st4, FREE, load4, 32'h0);
        chk("reset_l1", st1, FREE, load1, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].store);
            chk($sformatf("vec%0d", i), st4, vecs[i].st, load4, vecs[i].load);
        end

        // Async reset mid-BUSY of a write drops it
        step(1'b0, 1'b1, 14'h020, 32'h00001234);
        chk("rst_w_busy1", st4, BUSY, load4, 32'h0);
        step(1'b0, 1'b1, 14'h020, 32'h00001234);
        chk("rst_w_busy2", st4, BUSY, load4, 32'h0);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_busy_l4", st4, FREE, load4, 32'h0);
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 14'h020, 32'h0);
            chk("rst_rd_busy", st4, BUSY, load4, 32'h0);
        end
        step(1'b1, 1'b0, 14'h020, 32'h0);
        chk("rst_rd_access", st4, ACCESS, load4, 32'h0);
        step(1'b0, 1'b0, 14'h0, 32'h0);
        chk("rst_rd_free", st4, FREE, load4, 32'h0);

        // LATENCY=1: ACCESS two cycles after the request
        step(1'b0, 1'b1, 14'h020, 32'h00001234);
        chk("l1_w_busy", st1, BUSY, load1, 32'h0);
        step(1'b0, 1'b1, 14'h020, 32'h00001234);
        chk("l1_w_access", st1, ACCESS, load1, 32'h0);
        step(1'b0, 1'b0, 14'h0, 32'h0);
        chk("l1_w_free", st1, FREE, load1, 32'h0);
        step(1'b1, 1'b0, 14'h020, 32'h0);
        chk("l1_r_busy", st1, BUSY, load1, 32'h0);
        step(1'b1, 1'b0, 14'h020, 32'h0);
        chk("l1_r_access", st1, ACCESS, load1, 32'h00001234);
        step(1'b0, 1'b0, 14'h0, 32'h0);
        chk("l1_r_free", st1, FREE, load1, 32'h0);

        // LATENCY=1: reset during the single BUSY cycle drops the write
        step(1'b0, 1'b1, 14'h020, 32'h00005678);
        chk("l1_rst_busy", st1, BUSY, load1, 32'h0);
        #2 RST = 1'b1;
        #1;
        chk("l1_rst_free", st1, FREE, load1, 32'h0);
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        step(1'b1, 1'b0, 14'h020, 32'h0);
        chk("l1_rd_busy", st1, BUSY, load1, 32'h0);
        step(1'b1, 1'b0, 14'h020, 32'h0);
        chk("l1_rd_access", st1, ACCESS, load1, 32'h0);
        step(1'b0, 1'b0, 14'h0, 32'h0);
        chk("l1_rd_free", st1, FREE, load1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ram_responder.md
Name: mem_ram_responder

Overview:
- Responder (RAM side) of the ramstate handshake driven by the memory controller.
- Samples read and write requests, models a fixed access latency, and reports FREE/BUSY/ACCESS/ERROR using ramstate_t from mem_types_pkg.
- Returns load data and commits store data to an internal word array.
- Serves as the backing memory for the memory controller in core/system benches and synthesis-side stand-ins.

Parameters:
- LATENCY, 4, number of BUSY cycles before ACCESS (legal range 1..15).
- MEM_DEPTH, 256, number of 32-bit words stored (power of 2).
- ADDR_WIDTH, 14, width of word address input (word address space of the core).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous active-high reset.
- ramREN  input  1  read request; held by initiator until ACCESS/ERROR.
- ramWEN  input  1  write request; held by initiator until ACCESS/ERROR.
- ramaddr  input  ADDR_WIDTH  word address of the request.
- ramstore  input  32  write data, sampled on the ACCESS-entry edge.
- ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  output  32  read data, valid only while ramstate==ACCESS for a read.

Behaviour:
- Reset (async, RST=1):
  - ramstate=FREE, ramload=0, latency counter=0, latched addr/op cleared.
  - All MEM_DEPTH words cleared to 0.
  - Deassertion takes effect at the next posedge.
- Request valid = ramREN^ramWEN. Conflict = ramREN&ramWEN. Out of range = ramaddr >= MEM_DEPTH.
- FREE:
  - conflict or out-of-range request -> ERROR.
  - valid request -> BUSY; latch addr and op (R/W); cnt <= LATENCY-1.
  - no request -> stay FREE.
- BUSY:
  - request dropped, or addr/op differs from latched -> abort.
    - If a new valid request is present: restart BUSY with the new addr/op and cnt <= LATENCY-1.
    - Otherwise -> FREE.
  - conflict -> ERROR.
  - cnt!=0 -> cnt-1, stay BUSY.
  - cnt==0 -> ACCESS.
    - Write: mem[addr] <= ramstore on this edge.
    - Read: ramload <= mem[addr] on this edge.
- ACCESS:
  - Lasts exactly one cycle.
  - Next edge: valid request present (same or new addr) -> BUSY as a fresh request, cnt <= LATENCY-1. Otherwise -> FREE.
  - An initiator holding the same request therefore gets repeated accesses; the controller must drop or change the request in the ACCESS cycle.
- ERROR:
  - Sticky while ramREN|ramWEN is asserted.
  - Both low -> FREE.
  - No memory update occurs in ERROR.
- ramload:
  - Registered; holds read data only during ACCESS of a read; 0 in all other states.
  - During write ACCESS it is 0.
- Timing: request first asserted in cycle 0 -> BUSY in cycles 1..LATENCY, ACCESS in cycle LATENCY+1. Total latency LATENCY+1 cycles.
- Read-after-write to the same addr returns the new data: the write commits on the ACCESS-entry edge, before any later read's ACCESS.
- Reset asserted mid-BUSY or mid-ACCESS: the in-flight write is dropped if the ACCESS-entry edge has not yet occurred; state goes to FREE immediately.
- Counter width: $clog2(LATENCY+1), minimum 1 bit. No wrap; it saturates at 0 by construction.

Test Plan:
- Reset, then write: ramWEN=1, addr=0x010, store=0xDEADBEEF, LATENCY=4.
  - -> BUSY cycles 1-4, ACCESS cycle 5, FREE cycle 6 after WEN dropped.
  - Then read of addr 0x010 -> ACCESS with ramload=0xDEADBEEF at cycle +5; ramload=0 in the FREE cycle.
- Address change mid-BUSY: read addr 0x004, change to 0x008 in cycle 2 -> counter restarts; ACCESS in cycle 7 with mem[0x008] returned, never mem[0x004].
- Conflict: ramREN=ramWEN=1 in FREE -> ERROR next cycle, held while either is high; both drop -> FREE. Memory unchanged (readback 0).
- Out of range: ramREN=1, addr=0x100 (MEM_DEPTH=256) -> ERROR; ramload stays 0.
- Held request: ramREN held at addr 0x001 through ACCESS -> BUSY again the next cycle; second ACCESS LATENCY+1 cycles later with the same data.
- Async reset mid-BUSY of a write to 0x020 (value 0x1234):
  - -> ramstate=FREE immediately without waiting for a clock.
  - A subsequent read of 0x020 returns 0.
  - Repeat with LATENCY=1: ACCESS appears 2 cycles after the request.
